key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the oven setpoint logic.
- Takes the two raw, active-low push-buttons: key1 means increase, key0 means decrease, and both together mean confirm.
- Produces clean single-cycle command pulses: inc, dec and confirm.
- Provides synchronization, debounce, chord detection (both keys) and auto-repeat on hold, so the setpoint logic never sees bounce, double-counts, or a stray inc/dec while a confirm chord is being pressed.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synced cycles required before a level change is accepted (10 ms at 50 MHz).
- CHORD_WINDOW, 5000000: cycles after the first key press during which a second key press is treated as a confirm chord.
- REPEAT_DELAY, 25000000: cycles a single key must be held after its first pulse before auto-repeat begins.
- REPEAT_RATE, 5000000: cycles between auto-repeat pulses.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  synchronous reset, active-low
- key0  in  1  raw button, active-low (0 = pressed), asynchronous to clk
- key1  in  1  raw button, active-low (0 = pressed), asynchronous to clk
- key0_level  out  1  debounced key0, active-high (1 = pressed)
- key1_level  out  1  debounced key1, active-high (1 = pressed)
- inc_pulse  out  1  one-cycle increase command
- dec_pulse  out  1  one-cycle decrease command
- confirm_pulse  out  1  one-cycle confirm command (both keys)

Behaviour:
- Reset:
  - Synchronous: sampled on posedge clk while rst_n=0.
  - Synchronizer flops are set to 1 (released).
  - Debounce counters, chord counter and repeat counter are cleared.
  - key0_level=0, key1_level=0, all pulses=0, FSM returns to IDLE.
  - Reset mid-operation aborts everything with no pulse. A key still held after reset is handled as a fresh press.
- Synchronizer: two flops per key, then inverted to active-high.
- Debounce (per key):
  - The counter clears whenever the synced value equals keyN_level.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES, keyN_level takes the synced value and the counter clears.
  - Latency from a raw edge to a level change is DEBOUNCE_CYCLES+2 cycles.
  - Any bounce shorter than DEBOUNCE_CYCLES produces no level change.
- FSM runs on the debounced levels. All pulses are registered: each is asserted for exactly one cycle, on the edge after the triggering condition. At most one pulse is asserted in any cycle.
  - IDLE:
    - Both levels rise in the same cycle: confirm_pulse, go to WAIT_RELEASE.
    - One level rises: go to PENDING(key) and clear the chord counter.
  - PENDING:
    - The chord counter increments each cycle.
    - Other key rises: confirm_pulse, go to WAIT_RELEASE. This has priority over expiry and over release.
    - Pending key falls before expiry: emit its pulse (tap), go to IDLE.
    - Chord counter reaches CHORD_WINDOW: emit its pulse, go to HELD and clear the repeat counter.
  - HELD:
    - Other key rises: confirm_pulse, go to WAIT_RELEASE.
    - Held key falls: go to IDLE.
    - If the held key falls and the other key rises in the same cycle: go to PENDING(other key).
    - Repeat counter reaches REPEAT_DELAY: pulse, go to REPEAT, clear the counter.
  - REPEAT: same exits as HELD. Each time the counter reaches REPEAT_RATE: pulse and clear the counter.
  - WAIT_RELEASE: no pulses. Go to IDLE only when both levels are 0.
- Pulse mapping: key1 gives inc_pulse, key0 gives dec_pulse.
- Counters:
  - Width is $clog2 of their parameter, plus 1.
  - They saturate and never wrap.
- A confirm event in the same cycle as a repeat or expiry event: confirm wins, and no inc/dec pulse is emitted.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, CHORD_WINDOW=8, REPEAT_DELAY=20, REPEAT_RATE=5; t=0 is the raw edge):
- Bounce rejection: key1 toggles every 2 cycles for 20 cycles, then released -> key1_level stays 0, no pulses.
- Tap: key0 low at t=0, high at t=5 -> key0_level high at t=6 and low at t=11; dec_pulse only at t=12.
- Hold with repeat: key1 low at t=0, released at t=42 -> inc_pulse at t=15, 35, 40, 45 (4 total); none after key1_level falls at t=48.
- Chord: key1 low at t=0, key0 low at t=4, both held 100 cycles -> confirm_pulse only at t=11; no inc/dec at any point; no further pulses until both are released.
- Reset mid-repeat: rst_n=0 for 3 cycles during REPEAT while key1 is held -> all outputs 0 on the next edge. After release of reset, key1_level re-rises 6 cycles later and inc_pulse follows 9 cycles after that.
- Same-cycle confirm vs expiry: key0 level rises exactly at chord-counter expiry -> confirm_pulse only, no inc_pulse.

Source files
------------

// File: rtl/key_conditioner.sv
// Two-button front end for the oven setpoint logic: synchronize, debounce, detect
// chords, auto-repeat on hold, and emit clean one-cycle inc/dec/confirm pulses.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHORD_WINDOW    = 5000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key0,
  input  logic key1,
  output logic key0_level,
  output logic key1_level,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic confirm_pulse
);

  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CW_W   = $clog2(CHORD_WINDOW) + 1;
  localparam int RP_W   = $clog2(RP_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PENDING,
    S_HELD,
    S_REPEAT,
    S_WAIT_RELEASE
  } state_t;

  logic [1:0]      meta;
  logic [1:0]      sync_q;
  logic [1:0]      synced;
  logic [1:0]      level;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state;
  logic            sel;
  logic [CW_W-1:0] chord_cnt;
  logic [RP_W-1:0] rep_cnt;

  // Index 1 is key1 (increase), index 0 is key0 (decrease).
  assign synced     = ~sync_q;
  assign key0_level = level[0];
  assign key1_level = level[1];

  // NOTE: reset is sampled on the clock edge only, so it is tested inside the
  // clocked block rather than listed in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta   <= {key1, key0};
      sync_q <= meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 2'b00;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (synced[k] == level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level[k]  <= synced[k];
          db_cnt[k] <= '0;
        end else if (db_cnt[k] != '1) begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Chord/repeat FSM; sel remembers which key owns PENDING/HELD/REPEAT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sel           <= 1'b0;
      chord_cnt     <= '0;
      rep_cnt       <= '0;
      inc_pulse     <= 1'b0;
      dec_pulse     <= 1'b0;
      confirm_pulse <= 1'b0;
    end else begin
      inc_pulse     <= 1'b0;
      dec_pulse     <= 1'b0;
      confirm_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (level[0] && level[1]) begin
            confirm_pulse <= 1'b1;
            state         <= S_WAIT_RELEASE;
          end else if (level[0] || level[1]) begin
            sel       <= level[1];
            chord_cnt <= '0;
            state     <= S_PENDING;
          end
        end

        S_PENDING: begin
          if (chord_cnt != '1) chord_cnt <= chord_cnt + CW_W'(1);
          // A second key always means confirm, even on the expiry cycle.
          if (level[~sel]) begin
            confirm_pulse <= 1'b1;
            state         <= S_WAIT_RELEASE;
          end else if (!level[sel]) begin
            inc_pulse <= sel;
            dec_pulse <= ~sel;
            state     <= S_IDLE;
          end else if (chord_cnt == CW_W'(CHORD_WINDOW - 1)) begin
            inc_pulse <= sel;
            dec_pulse <= ~sel;
            rep_cnt   <= '0;
            state     <= S_HELD;
          end
        end

        S_HELD, S_REPEAT: begin
          if (rep_cnt != '1) rep_cnt <= rep_cnt + RP_W'(1);
          if (level[~sel] && level[sel]) begin
            confirm_pulse <= 1'b1;
            state         <= S_WAIT_RELEASE;
          end else if (level[~sel]) begin
            sel       <= ~sel;
            chord_cnt <= '0;
            state     <= S_PENDING;
          end else if (!level[sel]) begin
            state <= S_IDLE;
          end else if ((state == S_HELD   && rep_cnt == RP_W'(REPEAT_DELAY - 1)) ||
                       (state == S_REPEAT && rep_cnt == RP_W'(REPEAT_RATE - 1))) begin
            inc_pulse <= sel;
            dec_pulse <= ~sel;
            rep_cnt   <= '0;
            state     <= S_REPEAT;
          end
        end

        S_WAIT_RELEASE: begin
          if (!level[0] && !level[1]) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: expected pulses (kind + edge index) are
// queued when stimulus is driven and matched by a negedge monitor.
module tb_key_conditioner;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic key0  = 1'b1;
  logic key1  = 1'b1;
  logic key0_level, key1_level, inc_pulse, dec_pulse, confirm_pulse;

  key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CHORD_WINDOW   (8),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key0         (key0),
    .key1         (key1),
    .key0_level   (key0_level),
    .key1_level   (key1_level),
    .inc_pulse    (inc_pulse),
    .dec_pulse    (dec_pulse),
    .confirm_pulse(confirm_pulse)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int          checks = 0;
  int          errors = 0;
  int          t0 = 0;
  logic [31:0] sb[$];
  logic [31:0] obs;

  localparam logic [2:0] K_CONF = 3'b100;
  localparam logic [2:0] K_INC  = 3'b010;
  localparam logic [2:0] K_DEC  = 3'b001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic [2:0] kind, input int t);
    return {kind, 29'(t)};
  endfunction

  always @(negedge clk) begin
    if (inc_pulse || dec_pulse || confirm_pulse) begin
      obs = ev({confirm_pulse, inc_pulse, dec_pulse}, edge_n);
      if (sb.size() == 0) check("pulse_unexpected", obs, 32'h0);
      else                check("pulse", obs, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int t);
    while (edge_n < t0 + t) tick();
  endtask

  task automatic start();
    tick();
    t0 = edge_n;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {27'd0, key0_level, key1_level, inc_pulse, dec_pulse, confirm_pulse}, 32'h0);
    rst_n = 1'b1;

    // Bounce shorter than the debounce window never produces a level.
    start();
    for (int i = 0; i < 10; i++) begin
      key1 = (i % 2 == 0) ? 1'b0 : 1'b1;
      at((i + 1) * 2);
    end
    key1 = 1'b1;
    at(40);
    check("bounce_level", {31'd0, key1_level}, 32'h0);
    check("bounce_sb_empty", sb.size(), 0);

    // Tap key0.
    start();
    sb.push_back(ev(K_DEC, t0 + 12));
    key0 = 1'b0;
    at(5);
    check("tap_level_t5", {31'd0, key0_level}, 32'h0);
    key0 = 1'b1;
    at(6);
    check("tap_level_t6", {31'd0, key0_level}, 32'h1);
    at(10);
    check("tap_level_t10", {31'd0, key0_level}, 32'h1);
    at(11);
    check("tap_level_t11", {31'd0, key0_level}, 32'h0);
    at(40);
    check("tap_sb_empty", sb.size(), 0);

    // Hold key1 with auto-repeat.
    start();
    sb.push_back(ev(K_INC, t0 + 15));
    sb.push_back(ev(K_INC, t0 + 35));
    sb.push_back(ev(K_INC, t0 + 40));
    sb.push_back(ev(K_INC, t0 + 45));
    key1 = 1'b0;
    at(42);
    key1 = 1'b1;
    at(47);
    check("hold_level_t47", {31'd0, key1_level}, 32'h1);
    at(48);
    check("hold_level_t48", {31'd0, key1_level}, 32'h0);
    at(80);
    check("hold_sb_empty", sb.size(), 0);

    // Chord: key1 then key0 inside the window.
    start();
    sb.push_back(ev(K_CONF, t0 + 11));
    key1 = 1'b0;
    at(4);
    key0 = 1'b0;
    at(104);
    check("chord_held_sb_empty", sb.size(), 0);
    check("chord_levels_held", {30'd0, key1_level, key0_level}, 32'h3);
    key0 = 1'b1;
    key1 = 1'b1;
    at(140);
    check("chord_sb_empty", sb.size(), 0);

    // Reset while repeating; the held key is then a fresh press.
    start();
    sb.push_back(ev(K_INC, t0 + 15));
    sb.push_back(ev(K_INC, t0 + 35));
    sb.push_back(ev(K_INC, t0 + 40));
    sb.push_back(ev(K_INC, t0 + 60));
    key1 = 1'b0;
    at(42);
    rst_n = 1'b0;
    at(43);
    check("rst_outputs", {27'd0, key0_level, key1_level, inc_pulse, dec_pulse, confirm_pulse}, 32'h0);
    at(45);
    rst_n = 1'b1;
    at(50);
    check("rst_level_t50", {31'd0, key1_level}, 32'h0);
    at(51);
    check("rst_level_t51", {31'd0, key1_level}, 32'h1);
    at(61);
    key1 = 1'b1;
    at(100);
    check("rst_sb_empty", sb.size(), 0);

    // Second key level rises exactly on the chord-window expiry cycle.
    start();
    sb.push_back(ev(K_CONF, t0 + 15));
    key1 = 1'b0;
    at(8);
    key0 = 1'b0;
    at(14);
    check("cvx_level_t14", {30'd0, key1_level, key0_level}, 32'h3);
    at(30);
    key0 = 1'b1;
    key1 = 1'b1;
    at(60);
    check("cvx_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
